// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// One outstanding transaction, req/gnt/rvalid handshake, starvation-bounded data priority.
module imem_dmem_arbiter #(
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_ADDR_WIDTH   = 11,
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_if_req,
    input  logic [P_ADDR_WIDTH-1:0]   i_if_addr,
    output logic [P_DATA_WIDTH-1:0]   o_if_rdata,
    output logic                      o_if_rvalid,
    output logic                      o_if_busy,
    input  logic                      i_dm_req,
    input  logic                      i_dm_we,
    input  logic [P_DATA_WIDTH/8-1:0] i_dm_be,
    input  logic [P_ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [P_DATA_WIDTH-1:0]   i_dm_wdata,
    output logic [P_DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                      o_dm_rvalid,
    output logic                      o_dm_busy,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [P_DATA_WIDTH/8-1:0] o_mem_be,
    output logic [P_ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [P_DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic                      i_mem_gnt,
    input  logic                      i_mem_rvalid,
    input  logic [P_DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int CNT_W = $clog2(P_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(P_STARVE_LIMIT);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_GNT = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic [1:0]       state;
    logic             owner;
    logic [CNT_W-1:0] starve_cnt;

    logic rsp_hit;
    logic arb_en;
    logic if_win;
    logic grant;

    // The response cycle doubles as an arbitration slot so a pending request issues back-to-back.
    always_comb begin
        rsp_hit = (state == S_WAIT_RSP) && i_mem_rvalid;
        arb_en  = (state == S_IDLE) || rsp_hit;
        if_win  = i_if_req && (!i_dm_req || (starve_cnt == STARVE_MAX));
        grant   = arb_en && (i_if_req || i_dm_req);
    end

    always_comb begin
        o_if_rvalid = rsp_hit && (owner == OWN_IF);
        o_dm_rvalid = rsp_hit && (owner == OWN_DM);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
        o_if_busy   = i_if_req && !o_if_rvalid;
        o_dm_busy   = i_dm_req && !o_dm_rvalid;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            owner       <= OWN_IF;
            starve_cnt  <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_WAIT_RSP: begin
                    if (grant) begin
                        state     <= S_WAIT_GNT;
                        o_mem_req <= 1'b1;
                        if (if_win) begin
                            owner       <= OWN_IF;
                            o_mem_we    <= 1'b0;
                            o_mem_be    <= '1;
                            o_mem_addr  <= i_if_addr;
                            o_mem_wdata <= '0;
                            starve_cnt  <= '0;
                        end else begin
                            owner       <= OWN_DM;
                            o_mem_we    <= i_dm_we;
                            o_mem_be    <= i_dm_be;
                            o_mem_addr  <= i_dm_addr;
                            o_mem_wdata <= i_dm_wdata;
                            // Only data grants that bypass a waiting fetch count toward starvation.
                            if (i_if_req && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end else if (rsp_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_GNT: begin
                    if (i_mem_gnt) begin
                        state     <= S_WAIT_RSP;
                        o_mem_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
